// File: rtl/fp16_to_int.sv
// Sequential IEEE-754 binary16 to saturating signed integer converter.
// Alignment shifts one bit per cycle, then rounds half-to-even and saturates.
module fp16_to_int #(
    parameter int OUT_W = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             ovf,
    output logic             inv,
    output logic             inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [32:0]      MAX_MAG = (33'd1 << (OUT_W - 1)) - 33'd1;
    localparam logic [32:0]      MIN_MAG = (33'd1 << (OUT_W - 1));

    state_t            state_q, state_d;
    logic [16:0]       mag_q, mag_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              left_q, left_d;
    logic              g_q, g_d;
    logic              st_q, st_d;
    logic              sign_q, sign_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              inv_q, inv_d;
    logic              inexact_q, inexact_d;

    logic              in_sign;
    logic [4:0]        in_exp;
    logic [9:0]        in_frac;
    logic [2:0]        lshift;
    logic [4:0]        rshift;
    logic              inc;
    logic [17:0]       mag_r;
    logic [32:0]       mag_ext;
    logic              pos_sat;
    logic              neg_sat;

    assign in_sign = in_data[15];
    assign in_exp  = in_data[14:10];
    assign in_frac = in_data[9:0];
    assign lshift  = 3'(in_exp - 5'd25);
    assign rshift  = 5'd25 - in_exp;

    assign inc     = g_q & (st_q | mag_q[0]);
    assign mag_r   = {1'b0, mag_q} + {17'd0, inc};
    assign mag_ext = {15'd0, mag_r};
    assign pos_sat = !sign_q && (mag_ext > MAX_MAG);
    assign neg_sat = sign_q && (mag_ext > MIN_MAG);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
            g_q       <= 1'b0;
            st_q      <= 1'b0;
            sign_q    <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            inv_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            g_q       <= g_d;
            st_q      <= st_d;
            sign_q    <= sign_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            inv_q     <= inv_d;
            inexact_q <= inexact_d;
        end
    end

    // The ALIGN exit is taken on the last shift (and ALIGN is skipped when no
    // shift is needed) so a normal operand reaches OUT cnt+2 edges after accept.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        g_d       = g_q;
        st_d      = st_q;
        sign_d    = sign_q;
        data_d    = data_q;
        ovf_d     = ovf_q;
        inv_d     = inv_q;
        inexact_d = inexact_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    mag_d  = {6'd0, 1'b1, in_frac};
                    g_d    = 1'b0;
                    st_d   = 1'b0;
                    cnt_d  = 4'd0;
                    left_d = 1'b0;
                    if (in_exp == 5'd31) begin
                        state_d   = OUT;
                        inv_d     = (in_frac != 10'd0);
                        ovf_d     = (in_frac == 10'd0);
                        inexact_d = 1'b0;
                        if (in_frac != 10'd0) begin
                            data_d = '0;
                        end else begin
                            data_d = in_sign ? MIN_VAL : MAX_VAL;
                        end
                    end else if (in_exp == 5'd0) begin
                        state_d   = OUT;
                        data_d    = '0;
                        ovf_d     = 1'b0;
                        inv_d     = 1'b0;
                        inexact_d = (in_frac != 10'd0);
                    end else begin
                        if (in_exp >= 5'd25) begin
                            left_d = 1'b1;
                            cnt_d  = {1'b0, lshift};
                        end else if (rshift > 5'd12) begin
                            cnt_d  = 4'd12;
                        end else begin
                            cnt_d  = rshift[3:0];
                        end
                        state_d = (cnt_d == 4'd0) ? ROUND : ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (left_q) begin
                        mag_d = {mag_q[15:0], 1'b0};
                    end else begin
                        st_d  = st_q | g_q;
                        g_d   = mag_q[0];
                        mag_d = {1'b0, mag_q[16:1]};
                    end
                    if (cnt_q == 4'd1) begin
                        state_d = ROUND;
                    end
                end else begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                state_d = OUT;
                inv_d   = 1'b0;
                if (pos_sat) begin
                    data_d    = MAX_VAL;
                    ovf_d     = 1'b1;
                    inexact_d = 1'b0;
                end else if (neg_sat) begin
                    data_d    = MIN_VAL;
                    ovf_d     = 1'b1;
                    inexact_d = 1'b0;
                end else begin
                    ovf_d     = 1'b0;
                    inexact_d = g_q | st_q;
                    if (sign_q) begin
                        data_d = ~mag_ext[OUT_W-1:0] + {{(OUT_W-1){1'b0}}, 1'b1};
                    end else begin
                        data_d = mag_ext[OUT_W-1:0];
                    end
                end
            end

            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = data_q;
    assign ovf       = ovf_q;
    assign inv       = inv_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp16_to_int.sv
// Scoreboard bench for fp16_to_int: a 16-bit and a 32-bit instance,
// directed vectors with hand-computed results, flags and latencies.
module tb_fp16_to_int;

   typedef struct packed {
      logic [31:0] data;
      logic        ovf;
      logic        inv;
      logic        inx;
      logic [31:0] lat;
      logic [31:0] acc;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESETn;

   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [15:0] in_data16, out_data16;
   logic        ovf16, inv16, inx16;

   logic        in_valid32, in_ready32, out_valid32, out_ready32;
   logic [15:0] in_data32;
   logic [31:0] out_data32;
   logic        ovf32, inv32, inx32;

   int          cyc = 0;
   int          nCompared = 0;
   int          nFailed = 0;

   exp_t        q16[$];
   exp_t        q32[$];
   string       nm16[$];
   string       nm32[$];

   logic        prev16 = 1'b0;
   logic        prev32 = 1'b0;
   exp_t        e16, e32;
   string       s16, s32;

   // Free-running clock and cycle counter used for latency measurement
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   fp16_to_int #(.OUT_W(16)) dut16 (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .in_data   (in_data16),
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .out_data  (out_data16),
      .ovf       (ovf16),
      .inv       (inv16),
      .inexact   (inx16)
   );

   fp16_to_int #(.OUT_W(32)) dut32 (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .in_data   (in_data32),
      .out_valid (out_valid32),
      .out_ready (out_ready32),
      .out_data  (out_data32),
      .ovf       (ovf32),
      .inv       (inv32),
      .inexact   (inx32)
   );

   // Single comparison point: every check in the bench funnels through here
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      nCompared++;
      if (act !== expv) begin
         nFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic reportTimeout(input string name);
      nCompared++;
      nFailed++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   // Monitor for the 16-bit instance: latency on the rising out_valid, data and flags on handshake
   always @(negedge CLK) begin
      if (RESETn) begin
         if (out_valid16 && !prev16) begin
            if (q16.size() == 0) begin
               reportTimeout("out16 unexpected output (no expected entry)");
            end else begin
               checkOutput({nm16[0], " latency"}, 32'(cyc) - q16[0].acc, q16[0].lat);
            end
         end
         if (out_valid16 && out_ready16 && q16.size() != 0) begin
            e16 = q16.pop_front();
            s16 = nm16.pop_front();
            checkOutput({s16, " data"}, {16'd0, out_data16}, e16.data);
            checkOutput({s16, " flags"}, {29'd0, ovf16, inv16, inx16}, {29'd0, e16.ovf, e16.inv, e16.inx});
         end
      end
      prev16 <= out_valid16;
   end

   // Monitor for the 32-bit instance
   always @(negedge CLK) begin
      if (RESETn) begin
         if (out_valid32 && !prev32) begin
            if (q32.size() == 0) begin
               reportTimeout("out32 unexpected output (no expected entry)");
            end else begin
               checkOutput({nm32[0], " latency"}, 32'(cyc) - q32[0].acc, q32[0].lat);
            end
         end
         if (out_valid32 && out_ready32 && q32.size() != 0) begin
            e32 = q32.pop_front();
            s32 = nm32.pop_front();
            checkOutput({s32, " data"}, out_data32, e32.data);
            checkOutput({s32, " flags"}, {29'd0, ovf32, inv32, inx32}, {29'd0, e32.ovf, e32.inv, e32.inx});
         end
      end
      prev32 <= out_valid32;
   end

   // Present one operand, wait for acceptance and queue the expected response
   task automatic applyStimulus(input bit which, input logic [15:0] din, input logic [31:0] edata,
                                input logic [2:0] eflags, input int lat, input string name);
      bit   accepted;
      exp_t ent;
      accepted = 1'b0;
      @(posedge CLK);
      #1;
      if (which) begin
         in_valid32 = 1'b1;
         in_data32  = din;
      end else begin
         in_valid16 = 1'b1;
         in_data16  = din;
      end
      for (int i = 0; i < 100 && !accepted; i++) begin
         @(negedge CLK);
         if (which ? in_ready32 : in_ready16) accepted = 1'b1;
      end
      if (!accepted) begin
         reportTimeout({name, " accept"});
      end else begin
         ent.data = edata;
         ent.ovf  = eflags[2];
         ent.inv  = eflags[1];
         ent.inx  = eflags[0];
         ent.lat  = 32'(lat);
         ent.acc  = 32'(cyc);
         if (which) begin
            q32.push_back(ent);
            nm32.push_back(name);
         end else begin
            q16.push_back(ent);
            nm16.push_back(name);
         end
      end
      @(posedge CLK);
      #1;
      if (which) begin
         in_valid32 = 1'b0;
         in_data32  = 16'hFFFF;
      end else begin
         in_valid16 = 1'b0;
         in_data16  = 16'hFFFF;
      end
   endtask

   task automatic waitDrain(input bit which, input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge CLK);
         if ((which ? q32.size() : q16.size()) == 0) done = 1'b1;
      end
      if (!done) reportTimeout({name, " drain"});
   endtask

   task automatic runOne(input bit which, input logic [15:0] din, input logic [31:0] edata,
                         input logic [2:0] eflags, input int lat, input string name);
      applyStimulus(which, din, edata, eflags, lat, name);
      waitDrain(which, name);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit seen;
      RESETn      = 1'b0;
      in_valid16  = 1'b0;
      in_data16   = 16'h0000;
      out_ready16 = 1'b1;
      in_valid32  = 1'b0;
      in_data32   = 16'h0000;
      out_ready32 = 1'b1;

      #12;
      checkOutput("reset16 in_ready", {31'd0, in_ready16}, 32'd1);
      checkOutput("reset16 out_valid", {31'd0, out_valid16}, 32'd0);
      checkOutput("reset16 out_data", {16'd0, out_data16}, 32'd0);
      checkOutput("reset16 flags", {29'd0, ovf16, inv16, inx16}, 32'd0);
      checkOutput("reset32 in_ready", {31'd0, in_ready32}, 32'd1);
      checkOutput("reset32 out_data", out_data32, 32'd0);
      @(negedge CLK);
      RESETn = 1'b1;

      // flags order: {ovf, inv, inexact}
      runOne(0, 16'h3C00, 32'h0000_0001, 3'b000, 12, "one");
      runOne(0, 16'h4100, 32'h0000_0002, 3'b001, 11, "2.5 ties even down");
      runOne(0, 16'h4300, 32'h0000_0004, 3'b001, 11, "3.5 ties even up");
      runOne(0, 16'hBE00, 32'h0000_FFFE, 3'b001, 12, "-1.5");
      runOne(0, 16'h3E00, 32'h0000_0002, 3'b001, 12, "1.5");
      runOne(0, 16'h3800, 32'h0000_0000, 3'b001, 13, "0.5");
      runOne(0, 16'h7BFF, 32'h0000_7FFF, 3'b100, 7, "65504 sat");
      runOne(0, 16'h7800, 32'h0000_7FFF, 3'b100, 7, "+32768 sat");
      runOne(0, 16'hF800, 32'h0000_8000, 3'b000, 7, "-32768 exact");
      runOne(0, 16'h6400, 32'h0000_0400, 3'b000, 2, "1024 no shift");
      runOne(0, 16'hFC00, 32'h0000_8000, 3'b100, 1, "-inf");
      runOne(0, 16'h7C00, 32'h0000_7FFF, 3'b100, 1, "+inf");
      runOne(0, 16'h7E00, 32'h0000_0000, 3'b010, 1, "nan");
      runOne(0, 16'h0001, 32'h0000_0000, 3'b001, 1, "subnormal");
      runOne(0, 16'h8000, 32'h0000_0000, 3'b000, 1, "neg zero");
      runOne(0, 16'h3400, 32'h0000_0000, 3'b001, 14, "0.25 capped");

      runOne(1, 16'h7BFF, 32'h0000_FFE0, 3'b000, 7, "w32 65504");
      runOne(1, 16'hFBFF, 32'hFFFF_0020, 3'b000, 7, "w32 -65504");

      // Backpressure: result must hold and a second operand must wait
      out_ready16 = 1'b0;
      applyStimulus(0, 16'h3C00, 32'h0000_0001, 3'b000, 12, "bp first");
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge CLK);
         if (out_valid16) seen = 1'b1;
      end
      if (!seen) reportTimeout("bp out_valid");
      @(posedge CLK);
      #1;
      in_valid16 = 1'b1;
      in_data16  = 16'h4300;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("bp hold data", {16'd0, out_data16}, 32'd1);
         checkOutput("bp hold flags", {29'd0, ovf16, inv16, inx16}, 32'd0);
         checkOutput("bp hold out_valid", {31'd0, out_valid16}, 32'd1);
         checkOutput("bp in_ready low", {31'd0, in_ready16}, 32'd0);
      end
      @(posedge CLK);
      #1;
      out_ready16 = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("bp in_ready after handshake", {31'd0, in_ready16}, 32'd1);
      checkOutput("bp out_valid after handshake", {31'd0, out_valid16}, 32'd0);
      e16.data = 32'h0000_0004;
      e16.ovf  = 1'b0;
      e16.inv  = 1'b0;
      e16.inx  = 1'b1;
      e16.lat  = 32'd11;
      e16.acc  = 32'(cyc);
      q16.push_back(e16);
      nm16.push_back("bp second");
      @(posedge CLK);
      #1;
      in_valid16 = 1'b0;
      in_data16  = 16'hFFFF;
      waitDrain(0, "bp second");

      // Reset during ALIGN drops the operand and clears outputs immediately
      applyStimulus(0, 16'h3C00, 32'h0000_0001, 3'b000, 12, "rst dropped");
      repeat (3) @(posedge CLK);
      #2;
      RESETn = 1'b0;
      #1;
      checkOutput("mid reset out_valid", {31'd0, out_valid16}, 32'd0);
      checkOutput("mid reset in_ready", {31'd0, in_ready16}, 32'd1);
      checkOutput("mid reset out_data", {16'd0, out_data16}, 32'd0);
      checkOutput("mid reset flags", {29'd0, ovf16, inv16, inx16}, 32'd0);
      q16.delete();
      nm16.delete();
      @(posedge CLK);
      #2;
      RESETn = 1'b1;
      repeat (20) @(negedge CLK);
      checkOutput("after reset no output", {31'd0, out_valid16}, 32'd0);
      runOne(0, 16'h4100, 32'h0000_0002, 3'b001, 11, "after reset 2.5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
